// File: rtl/fsm_slave.sv
// fsm_slave: bit-level I2C-style slave FSM (address match, write receive, read transmit).
// Define SLAVE_GLITCH_FILTER_EN to insert a 3-sample glitch filter after the synchronizers.
module fsm_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [6:0] slave_addr,
  input  logic [7:0] tx_data,
  output logic       sda_out,
  output logic       sda_select,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s;
  logic scl_f, sda_f;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       sda_out_q, sda_out_d;
  logic       sda_sel_q, sda_sel_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] rx_byte;
  logic       load_tx;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_s};
      sda_hist_q <= {sda_hist_q[0], sda_s};
      scl_flt_q  <= scl_f;
      sda_flt_q  <= sda_f;
    end
  end

  // A new level is accepted only once the current and two previous samples agree.
  assign scl_f = (scl_s == scl_hist_q[0] && scl_s == scl_hist_q[1]) ? scl_s : scl_flt_q;
  assign sda_f = (sda_s == sda_hist_q[0] && sda_s == sda_hist_q[1]) ? sda_s : sda_flt_q;
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      sda_out_q  <= 1'b1;
      sda_sel_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_out_q  <= sda_out_d;
      sda_sel_q  <= sda_sel_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_out_d  = sda_out_q;
    sda_sel_d  = sda_sel_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    load_tx    = 1'b0;
    rx_byte    = {shift_q, sda_f};

    if (start_det) begin
      state_d   = ADDR;
      cnt_d     = 3'd0;
      sda_sel_d = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      cnt_d     = 3'd0;
      sda_sel_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7)
              state_d = (rx_byte[7:1] == slave_addr) ? ADDR_ACK : IDLE;
          end
        end
        // First fall after bit 8 drives ACK, the fall ending bit 9 releases it.
        ADDR_ACK, RX_ACK: begin
          if (scl_fall) begin
            if (!sda_sel_q) begin
              sda_sel_d = 1'b1;
              sda_out_d = 1'b0;
            end else begin
              sda_sel_d = 1'b0;
              cnt_d     = 3'd0;
              if (state_q == RX_ACK || !shift_q[0])
                state_d = RX;
              else
                load_tx = 1'b1;
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = RX_ACK;
            end
          end
        end
        TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              sda_sel_d = 1'b0;
              state_d   = TX_ACK;
            end else begin
              cnt_d     = cnt_q + 3'd1;
              sda_out_d = shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
            end
          end
        end
        // A NACK leaves at the rise, so any fall seen here follows a master ACK.
        TX_ACK: begin
          if (scl_rise && sda_f)
            state_d = IDLE;
          else if (scl_fall)
            load_tx = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (load_tx) begin
      state_d   = TX;
      cnt_d     = 3'd0;
      shift_d   = tx_data[6:0];
      sda_sel_d = 1'b1;
      sda_out_d = tx_data[7];
      tx_req_d  = 1'b1;
    end

    if (!sda_sel_d)
      sda_out_d = 1'b1;
  end

  assign sda_out    = sda_out_q;
  assign sda_select = sda_sel_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_req     = tx_req_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fsm_slave.sv
// Testbench for fsm_slave: bit-banged bus master with a transaction-level expectation model.
module tb_fsm_slave;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       scl_in = 1'b1;
  logic       masterSda = 1'b1;
  logic       sda_in;
  logic [6:0] slave_addr = 7'h2A;
  logic [7:0] tx_data = 8'h00;
  logic       sda_out, sda_select, rx_valid, tx_req, busy;
  logic [7:0] rx_data;

  int testCount = 0;
  int failCount = 0;
  int txReqCount = 0;
  int selCount = 0;
  int relViolations = 0;
  logic [7:0] rxSeen[$];
  logic [7:0] payload[$];

  // Open-drain bus: either side can pull SDA low.
  assign sda_in = masterSda & (sda_select ? sda_out : 1'b1);

  always #5 clk = ~clk;

  fsm_slave #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .slave_addr (slave_addr),
    .tx_data    (tx_data),
    .sda_out    (sda_out),
    .sda_select (sda_select),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_req     (tx_req),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) rxSeen.push_back(rx_data);
    if (tx_req) txReqCount++;
    if (sda_select) selCount++;
    if (!sda_select && sda_out !== 1'b1) relViolations++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic busStart();
    masterSda = 1'b1;
    waitCycles(Q);
    scl_in = 1'b1;
    waitCycles(2 * Q);
    masterSda = 1'b0;
    waitCycles(2 * Q);
    scl_in = 1'b0;
  endtask

  task automatic busStop();
    waitCycles(Q);
    masterSda = 1'b0;
    waitCycles(Q);
    scl_in = 1'b1;
    waitCycles(2 * Q);
    masterSda = 1'b1;
    waitCycles(2 * Q);
  endtask

  task automatic sendBit(input logic b);
    waitCycles(Q);
    masterSda = b;
    waitCycles(Q);
    scl_in = 1'b1;
    waitCycles(2 * Q);
    scl_in = 1'b0;
  endtask

  task automatic readBit(output logic b);
    waitCycles(Q);
    masterSda = 1'b1;
    waitCycles(Q);
    scl_in = 1'b1;
    waitCycles(Q);
    b = sda_in;
    waitCycles(Q);
    scl_in = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) sendBit(v[i]);
    readBit(b);
    ack = ~b;
  endtask

  // One complete transaction; expectations come from the bus rules, not the slave's internals.
  task automatic applyStimulus(input logic [6:0] addr, input logic rw, input string name);
    logic ack, bitVal, expAck;
    logic [7:0] got;
    logic [7:0] expRx[$];
    int rx0, tx0, sel0, n;
    n = payload.size();
    expAck = (addr == slave_addr);
    rx0 = rxSeen.size();
    tx0 = txReqCount;
    sel0 = selCount;
    if (n > 0) tx_data = payload[0];
    busStart();
    sendByte({addr, rw}, ack);
    checkOutput({name, " addr ack"}, 32'(ack), 32'(expAck));
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        sendByte(payload[i], ack);
        checkOutput({name, " data ack"}, 32'(ack), 32'(expAck));
        if (expAck) expRx.push_back(payload[i]);
      end
    end else if (expAck) begin
      for (int i = 0; i < n; i++) begin
        for (int b = 7; b >= 0; b--) begin
          readBit(bitVal);
          got[b] = bitVal;
        end
        checkOutput({name, " read byte"}, 32'(got), 32'(payload[i]));
        if (i < n - 1) tx_data = payload[i + 1];
        sendBit(i == n - 1);
      end
    end
    busStop();
    checkOutput({name, " busy after stop"}, 32'(busy), 32'd0);
    checkOutput({name, " sda released"}, 32'(sda_select), 32'd0);
    checkOutput({name, " rx_valid count"}, 32'(rxSeen.size() - rx0), 32'(expRx.size()));
    for (int i = 0; i < expRx.size() && rx0 + i < rxSeen.size(); i++)
      checkOutput({name, " rx_data"}, 32'(rxSeen[rx0 + i]), 32'(expRx[i]));
    checkOutput({name, " tx_req count"}, 32'(txReqCount - tx0), (rw && expAck) ? 32'(n) : 32'd0);
    if (!expAck)
      checkOutput({name, " sda untouched"}, 32'(selCount - sel0), 32'd0);
  endtask

`ifdef SLAVE_GLITCH_FILTER_EN
  task automatic glitchTest(input int len, input logic expBusy, input string name);
    logic saw;
    waitCycles(10);
    masterSda = 1'b0;
    waitCycles(len);
    masterSda = 1'b1;
    saw = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    checkOutput(name, 32'(saw), 32'(expBusy));
    waitCycles(10);
  endtask
`endif

  initial begin
    logic ack, b;
    logic [7:0] pattern;
    int rx0, sel0;

    repeat (3) @(negedge clk);
    checkOutput("reset sda_select", 32'(sda_select), 32'd0);
    checkOutput("reset sda_out", 32'(sda_out), 32'd1);
    checkOutput("reset rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset tx_req", 32'(tx_req), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_ = 1'b1;
    waitCycles(5);
    checkOutput("idle busy", 32'(busy), 32'd0);

    slave_addr = 7'h2A;
    payload = '{8'hA5};
    applyStimulus(7'h2A, 1'b0, "write A5");

    payload = '{};
    applyStimulus(7'h2B, 1'b0, "wrong addr");

    payload = '{8'h3C, 8'hC3};
    applyStimulus(7'h2A, 1'b1, "read 3C C3");

    // Aborted byte, then stop, start, repeated start.
    rx0 = rxSeen.size();
    busStart();
    sendByte(8'h54, ack);
    checkOutput("abort addr ack", 32'(ack), 32'd1);
    pattern = 8'hB0;
    for (int i = 7; i >= 4; i--) sendBit(pattern[i]);
    busStop();
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort rx_valid", 32'(rxSeen.size() - rx0), 32'd0);
    busStart();
    sendByte(8'h54, ack);
    checkOutput("pre-restart ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 5; i--) sendBit(pattern[i]);
    busStart();
    sendByte(8'h54, ack);
    checkOutput("restart ack", 32'(ack), 32'd1);
    sendByte(8'h11, ack);
    checkOutput("restart data ack", 32'(ack), 32'd1);
    busStop();
    checkOutput("restart rx count", 32'(rxSeen.size() - rx0), 32'd1);
    if (rxSeen.size() > 0)
      checkOutput("restart rx_data", 32'(rxSeen[$]), 32'h11);

    // Reset while the slave is driving ACK.
    busStart();
    pattern = 8'h54;
    for (int i = 7; i >= 0; i--) sendBit(pattern[i]);
    waitCycles(Q);
    masterSda = 1'b1;
    waitCycles(Q);
    checkOutput("ack driven", 32'(sda_select), 32'd1);
    #2 rst_ = 1'b0;
    #1;
    checkOutput("async release", 32'(sda_select), 32'd0);
    checkOutput("async sda_out", 32'(sda_out), 32'd1);
    checkOutput("async busy", 32'(busy), 32'd0);
    waitCycles(2);
    rst_ = 1'b1;
    scl_in = 1'b1;
    waitCycles(Q);
    b = sda_in;
    checkOutput("no ack after reset", 32'(b), 32'd1);
    waitCycles(Q);
    scl_in = 1'b0;
    sel0 = selCount;
    sendByte(8'h54, ack);
    checkOutput("bus ignored after reset", 32'(ack), 32'd0);
    checkOutput("no drive after reset", 32'(selCount - sel0), 32'd0);
    busStop();
    payload = '{8'h77};
    applyStimulus(7'h2A, 1'b0, "after reset");

    for (int t = 0; t < 12; t++) begin
      logic [6:0] a;
      logic rw;
      int n;
      slave_addr = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) a = slave_addr;
      else a = slave_addr ^ 7'($urandom_range(1, 127));
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
      applyStimulus(a, rw, "random");
    end

`ifdef SLAVE_GLITCH_FILTER_EN
    glitchTest(2, 1'b0, "glitch 2 cycles");
    glitchTest(3, 1'b1, "glitch 3 cycles");
`endif

    checkOutput("sda_out high when released", 32'(relViolations), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fsm_slave.md
FSM_SLAVE -- requirements
Module: fsm_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth on scl_in/sda_in; legal values 2..3.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_  input  1  asynchronous, active-low reset.
REQ-004 scl_in  input  1  bus SCL, driven by the master's scl_out.
REQ-005 sda_in  input  1  bus SDA as seen on the wire.
REQ-006 slave_addr  input  7  own 7-bit address; must be static during a transfer.
REQ-007 tx_data  input  8  byte returned on reads; sampled at each byte load.
REQ-008 sda_out  output  1  SDA value driven when sda_select=1.
REQ-009 sda_select  output  1  1 = slave drives SDA; 0 = SDA released.
REQ-010 rx_data  output  8  last byte received in a write.
REQ-011 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-012 tx_req  output  1  one-cycle pulse when tx_data has just been loaded.
REQ-013 busy  output  1  1 whenever state is not IDLE.

Function
REQ-014 scl_in/sda_in pass through SYNC_STAGES flops; scl rise, scl fall and sda edges are detected on synchronized values.
REQ-015 START = synced sda falls while synced scl high; STOP = synced sda rises while synced scl high.
REQ-016 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK.
REQ-017 START in any state -> ADDR, bit counter cleared, sda_select=0 (repeated START supported).
REQ-018 STOP in any state -> IDLE, sda_select=0 within one cycle of detection.
REQ-019 Data bits are sampled on scl rise, MSB first; a 3-bit counter marks the 8th bit.
REQ-020 ADDR: after 8th bit, if bits[7:1]==slave_addr -> ADDR_ACK; else -> IDLE with bus untouched until next START.
REQ-021 ACK drive: on the scl fall ending bit 8, sda_select=1, sda_out=0; released on the scl fall ending bit 9.
REQ-022 ADDR_ACK exit: R/W bit=0 -> RX; R/W bit=1 -> TX.
REQ-023 RX: on 8th scl rise, rx_data loaded and rx_valid pulses the following cycle; then RX_ACK (ACK per REQ-021), then RX for next byte.
REQ-024 TX: tx_data loaded into shift register at the scl fall ending the ACK bit, tx_req pulses that cycle; sda_select=1, sda_out=MSB; shifts on each following scl fall.
REQ-025 After 8th TX bit, the scl fall releases SDA -> TX_ACK; master bit sampled on the 9th scl rise.
REQ-026 TX_ACK: sampled 0 -> reload next byte per REQ-024; sampled 1 (NACK) -> IDLE, SDA released.
REQ-027 START/STOP detection takes priority over bit sampling in the same cycle.
REQ-028 sda_out=1 whenever sda_select=0.

Reset
REQ-029 rst_ low asynchronously forces: state IDLE, counter 0, sda_out=1, sda_select=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0; synchronizer flops=1.
REQ-030 Reset mid-transfer releases SDA immediately; after release, the block ignores the bus until a fresh START.

Configuration
REQ-031 Macro SLAVE_GLITCH_FILTER_EN defined: synced scl/sda feed a filter accepting a new level only after 3 consecutive equal samples (+2 cycles latency); pulses of 2 cycles or shorter are ignored.
REQ-032 Macro SLAVE_GLITCH_FILTER_EN undefined: no filter; synchronizer output is used directly.

Verification
REQ-033 slave_addr=7'h2A; START, byte 0x54, byte 0xA5, STOP -> ACK low on both 9th bits; rx_valid pulses once with rx_data=8'hA5; busy=0 after STOP.
REQ-034 slave_addr=7'h2A; START, byte 0x56 -> sda_select stays 0 throughout; state IDLE; rx_valid never pulses.
REQ-035 START, byte 0x55, tx_data=8'h3C, master ACK, tx_data=8'hC3, master NACK -> SDA bits 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1; tx_req pulses twice; release after NACK.
REQ-036 STOP after 4 bits of an RX byte -> IDLE, no rx_valid; repeated START then address 0x54 -> ACKed.
REQ-037 rst_ asserted during the ACK drive -> sda_select=0 asynchronously; no ACK until the next START.
REQ-038 With SLAVE_GLITCH_FILTER_EN: 2-cycle low glitch on sda while scl high -> no START detected; 3-cycle low -> START detected.
